sparc_ifu_wselgen: RTL and testbench

//  Parametrised I-cache way-select datapath for the IFU. Sits between icd data arrays and fdp/errdp/mbist.

---
 rtl/sparc_ifu_wselgen.sv | 152 +++++++++++++++
 tb/tb_sparc_ifu_wselgen.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/sparc_ifu_wselgen.sv
// I-cache way-select datapath: AND-OR fetch select, ASI/BIST capture sequencer, waysel mutex checker.
// Optional fetch parity check is built when WSEL_PARITY_EN is defined.
module sparc_ifu_wselgen #(
   parameter int NUM_WAYS  = 4,
   parameter int WAY_IDX_W = 2,
   parameter int DATA_W    = 34,
   parameter int ERRCNT_W  = 4
) (
   input  logic                       rclk,
   input  logic                       reset,
   input  logic [NUM_WAYS-1:0]        waysel_s1,
   input  logic [NUM_WAYS*DATA_W-1:0] fetdata_s1,
   input  logic [NUM_WAYS*DATA_W-1:0] topdata_s1,
   input  logic                       asi_req_f,
   input  logic [WAY_IDX_W-1:0]       asi_way_f,
   input  logic                       asi_ack,
   output logic [DATA_W-1:0]          fetdata_sel_s1,
   output logic [DATA_W-1:0]          topdata_sel_s1,
   output logic                       asi_busy,
   output logic                       asi_vld,
   output logic [2*DATA_W-1:0]        asi_data,
   output logic                       mutex_err,
   output logic [ERRCNT_W-1:0]        mutex_errcnt,
   output logic                       par_err
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CAPT = 2'd1,
      HOLD = 2'd2
   } asi_state_e;

   asi_state_e            state_q, state_d;
   logic [WAY_IDX_W-1:0]  way_q, way_d;
   logic [DATA_W-1:0]     fet_hold_q, fet_hold_d;
   logic [DATA_W-1:0]     top_hold_q, top_hold_d;
   logic                  mutex_err_q, mutex_err_d;
   logic [ERRCNT_W-1:0]   errcnt_q, errcnt_d;
   logic                  multi_hot;
   logic [DATA_W-1:0]     fet_way, top_way;

   // AND-OR way select; multi-hot ORs the hit ways together
   always_comb begin
      fetdata_sel_s1 = '0;
      topdata_sel_s1 = '0;
      for (int i = 0; i < NUM_WAYS; i++) begin
         fetdata_sel_s1 |= fetdata_s1[i*DATA_W +: DATA_W] & {DATA_W{waysel_s1[i]}};
         topdata_sel_s1 |= topdata_s1[i*DATA_W +: DATA_W] & {DATA_W{waysel_s1[i]}};
      end
   end

   assign multi_hot = |(waysel_s1 & (waysel_s1 - NUM_WAYS'(1)));

   // sticky mutex flag and saturating violation counter
   always_comb begin
      mutex_err_d = mutex_err_q | multi_hot;
      errcnt_d    = errcnt_q;
      if (multi_hot && (errcnt_q != '1))
         errcnt_d = errcnt_q + ERRCNT_W'(1);
   end

   // pick the latched ASI way out of the s1 data buses
   always_comb begin
      fet_way = '0;
      top_way = '0;
      for (int i = 0; i < NUM_WAYS; i++) begin
         if (way_q == WAY_IDX_W'(i)) begin
            fet_way = fetdata_s1[i*DATA_W +: DATA_W];
            top_way = topdata_s1[i*DATA_W +: DATA_W];
         end
      end
   end

   // ASI sequencer next state: requests only accepted in IDLE, ack only in HOLD
   always_comb begin
      state_d    = state_q;
      way_d      = way_q;
      fet_hold_d = fet_hold_q;
      top_hold_d = top_hold_q;
      unique case (state_q)
         IDLE: begin
            if (asi_req_f) begin
               way_d   = asi_way_f;
               state_d = CAPT;
            end
         end
         CAPT: begin
            fet_hold_d = fet_way;
            top_hold_d = top_way;
            state_d    = HOLD;
         end
         HOLD: begin
            if (asi_ack)
               state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // state and datapath registers
   always_ff @(posedge rclk) begin
      if (reset) begin
         state_q     <= IDLE;
         way_q       <= '0;
         fet_hold_q  <= '0;
         top_hold_q  <= '0;
         mutex_err_q <= 1'b0;
         errcnt_q    <= '0;
      end else begin
         state_q     <= state_d;
         way_q       <= way_d;
         fet_hold_q  <= fet_hold_d;
         top_hold_q  <= top_hold_d;
         mutex_err_q <= mutex_err_d;
         errcnt_q    <= errcnt_d;
      end
   end

`ifdef WSEL_PARITY_EN
   logic par_err_q, par_err_d;
   logic one_hot;

   assign one_hot = (waysel_s1 != '0) && !multi_hot;

   // odd parity on a clean one-hot select flags an error next cycle
   always_comb begin
      par_err_d = one_hot && (^fetdata_sel_s1);
   end

   // parity error pulse register
   always_ff @(posedge rclk) begin
      if (reset)
         par_err_q <= 1'b0;
      else
         par_err_q <= par_err_d;
   end

   assign par_err = par_err_q;
`else
   assign par_err = 1'b0;
`endif

   assign asi_busy     = (state_q != IDLE);
   assign asi_vld      = (state_q == HOLD);
   assign asi_data     = {top_hold_q[DATA_W-1:DATA_W-2],
                          fet_hold_q[DATA_W-1:DATA_W-2],
                          top_hold_q[DATA_W-3:0],
                          fet_hold_q[DATA_W-3:0]};
   assign mutex_err    = mutex_err_q;
   assign mutex_errcnt = errcnt_q;

endmodule

// File: tb/tb_sparc_ifu_wselgen.sv
// Directed bench for sparc_ifu_wselgen: fetch select, mutex checker, ASI sequencer, parity.
// Parity expectations follow WSEL_PARITY_EN.
module tb_sparc_ifu_wselgen;

   localparam int NW = 4;
   localparam int IW = 2;
   localparam int DW = 34;
   localparam int CW = 4;

   logic               rclk;
   logic               reset;
   logic [NW-1:0]      waysel_s1;
   logic [NW*DW-1:0]   fetdata_s1;
   logic [NW*DW-1:0]   topdata_s1;
   logic               asi_req_f;
   logic [IW-1:0]      asi_way_f;
   logic               asi_ack;
   logic [DW-1:0]      fetdata_sel_s1;
   logic [DW-1:0]      topdata_sel_s1;
   logic               asi_busy;
   logic               asi_vld;
   logic [2*DW-1:0]    asi_data;
   logic               mutex_err;
   logic [CW-1:0]      mutex_errcnt;
   logic               par_err;

   logic [DW-1:0]      fet [NW];
   logic [DW-1:0]      top [NW];

   int tests;
   int fails;
   logic par_exp;

   sparc_ifu_wselgen #(
      .NUM_WAYS(NW), .WAY_IDX_W(IW), .DATA_W(DW), .ERRCNT_W(CW)
   ) dut (
      .rclk(rclk), .reset(reset), .waysel_s1(waysel_s1),
      .fetdata_s1(fetdata_s1), .topdata_s1(topdata_s1),
      .asi_req_f(asi_req_f), .asi_way_f(asi_way_f), .asi_ack(asi_ack),
      .fetdata_sel_s1(fetdata_sel_s1), .topdata_sel_s1(topdata_sel_s1),
      .asi_busy(asi_busy), .asi_vld(asi_vld), .asi_data(asi_data),
      .mutex_err(mutex_err), .mutex_errcnt(mutex_errcnt), .par_err(par_err)
   );

   initial rclk = 1'b0;
   always #5 rclk = ~rclk;

   always_comb begin
      for (int i = 0; i < NW; i++) begin
         fetdata_s1[i*DW +: DW] = fet[i];
         topdata_s1[i*DW +: DW] = top[i];
      end
   end

   task automatic tick();
      @(posedge rclk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [2*DW-1:0] obs, input logic [2*DW-1:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   initial begin
      tests = 0;
      fails = 0;
`ifdef WSEL_PARITY_EN
      par_exp = 1'b1;
`else
      par_exp = 1'b0;
`endif
      reset = 1'b1;
      waysel_s1 = '0;
      asi_req_f = 1'b0;
      asi_way_f = '0;
      asi_ack = 1'b0;
      fet[0] = 34'h0_1111_0000; top[0] = 34'h0_AAAA_0000;
      fet[1] = 34'h0_0000_2222; top[1] = 34'h1_0000_BBBB;
      fet[2] = 34'h1_2345_6789; top[2] = 34'h2_CCCC_CCCC;
      fet[3] = 34'h3_0000_0002; top[3] = 34'h2_0000_0001;
      tick();
      tick();
      chk("rst_busy", 68'(asi_busy), 68'(0));
      chk("rst_vld", 68'(asi_vld), 68'(0));
      chk("rst_data", 68'(asi_data), 68'(0));
      chk("rst_merr", 68'(mutex_err), 68'(0));
      chk("rst_cnt", 68'(mutex_errcnt), 68'(0));
      chk("rst_par", 68'(par_err), 68'(0));
      reset = 1'b0;
      tick();

      // one-hot fetch select, same cycle
      waysel_s1 = 4'b0100;
      #1;
      chk("sel_fet_w2", 68'(fetdata_sel_s1), 68'(34'h1_2345_6789));
      chk("sel_top_w2", 68'(topdata_sel_s1), 68'(34'h2_CCCC_CCCC));
      tick();
      chk("onehot_merr", 68'(mutex_err), 68'(0));
      waysel_s1 = 4'b1000;
      #1;
      chk("sel_fet_w3", 68'(fetdata_sel_s1), 68'(34'h3_0000_0002));

      // zero select
      waysel_s1 = 4'b0000;
      #1;
      chk("sel_fet_zero", 68'(fetdata_sel_s1), 68'(0));
      chk("sel_top_zero", 68'(topdata_sel_s1), 68'(0));
      tick();

      // parity: odd vs even on one-hot select
      fet[0] = 34'h0_0000_0001;
      waysel_s1 = 4'b0001;
      tick();
      chk("par_odd", 68'(par_err), 68'(par_exp));
      fet[0] = 34'h0_0000_0003;
      tick();
      chk("par_even", 68'(par_err), 68'(0));
      waysel_s1 = 4'b0000;
      tick();
      chk("par_zero_sel", 68'(par_err), 68'(0));

      // multi-hot: OR of ways, mutex count saturates
      fet[0] = 34'h0_0000_0001;
      fet[1] = 34'h0_0000_2222;
      waysel_s1 = 4'b0011;
      #1;
      chk("sel_fet_multi", 68'(fetdata_sel_s1), 68'(34'h0_0000_2223));
      chk("sel_top_multi", 68'(topdata_sel_s1), 68'(34'h1_AAAA_BBBB));
      tick();
      chk("merr_c1", 68'(mutex_err), 68'(1));
      chk("cnt_c1", 68'(mutex_errcnt), 68'(1));
      chk("par_multi", 68'(par_err), 68'(0));
      for (int i = 2; i <= 15; i++) tick();
      chk("cnt_c15", 68'(mutex_errcnt), 68'(4'hF));
      for (int i = 16; i <= 20; i++) tick();
      chk("cnt_sat", 68'(mutex_errcnt), 68'(4'hF));
      waysel_s1 = 4'b0000;
      tick();
      chk("merr_sticky", 68'(mutex_err), 68'(1));
      reset = 1'b1;
      tick();
      reset = 1'b0;
      chk("cnt_rst", 68'(mutex_errcnt), 68'(0));
      chk("merr_rst", 68'(mutex_err), 68'(0));
      tick();

      // ASI read of way 3
      asi_req_f = 1'b1;
      asi_way_f = 2'd3;
      fet[3] = 34'h0_DEAD_0000;
      top[3] = 34'h0_BEEF_0000;
      tick();
      asi_req_f = 1'b0;
      asi_way_f = 2'd0;
      chk("asi_busy_capt", 68'(asi_busy), 68'(1));
      chk("asi_vld_capt", 68'(asi_vld), 68'(0));
      fet[3] = 34'h3_0000_0002;
      top[3] = 34'h2_0000_0001;
      tick();
      chk("asi_vld_hold", 68'(asi_vld), 68'(1));
      chk("asi_data", 68'(asi_data), {2'b10, 2'b11, 32'h1, 32'h2});
      fet[3] = 34'h0_5555_5555;
      top[3] = 34'h1_6666_6666;
      for (int i = 0; i < 5; i++) tick();
      chk("asi_vld_stable", 68'(asi_vld), 68'(1));
      chk("asi_data_stable", 68'(asi_data), {2'b10, 2'b11, 32'h1, 32'h2});
      asi_ack = 1'b1;
      tick();
      asi_ack = 1'b0;
      chk("asi_vld_ack", 68'(asi_vld), 68'(0));
      chk("asi_busy_ack", 68'(asi_busy), 68'(0));

      // req during CAPT and HOLD, ack+req together
      fet[1] = 34'h1_0000_0011;
      top[1] = 34'h0_0000_0022;
      fet[0] = 34'h0_0000_0777;
      top[0] = 34'h0_0000_0888;
      asi_req_f = 1'b1;
      asi_way_f = 2'd1;
      tick();
      asi_way_f = 2'd0;
      tick();
      chk("busy_req_capt", 68'(asi_vld), 68'(1));
      chk("busy_data_w1", 68'(asi_data), {2'b00, 2'b01, 32'h22, 32'h11});
      tick();
      chk("busy_req_hold", 68'(asi_data), {2'b00, 2'b01, 32'h22, 32'h11});
      asi_ack = 1'b1;
      tick();
      asi_ack = 1'b0;
      asi_req_f = 1'b0;
      chk("ackreq_busy", 68'(asi_busy), 68'(0));
      tick();
      chk("ackreq_dropped", 68'(asi_busy), 68'(0));

      // reset during CAPT, then a clean request
      asi_req_f = 1'b1;
      asi_way_f = 2'd2;
      tick();
      asi_req_f = 1'b0;
      chk("capt_busy", 68'(asi_busy), 68'(1));
      reset = 1'b1;
      tick();
      reset = 1'b0;
      chk("rcapt_busy", 68'(asi_busy), 68'(0));
      chk("rcapt_vld", 68'(asi_vld), 68'(0));
      chk("rcapt_data", 68'(asi_data), 68'(0));
      tick();
      chk("rcapt_idle", 68'(asi_busy), 68'(0));
      asi_req_f = 1'b1;
      asi_way_f = 2'd3;
      tick();
      asi_req_f = 1'b0;
      fet[3] = 34'h3_0000_0002;
      top[3] = 34'h2_0000_0001;
      tick();
      chk("post_rst_vld", 68'(asi_vld), 68'(1));
      chk("post_rst_data", 68'(asi_data), {2'b10, 2'b11, 32'h1, 32'h2});
      asi_ack = 1'b1;
      tick();
      asi_ack = 1'b0;
      chk("post_rst_ack", 68'(asi_vld), 68'(0));

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
